// File: rtl/frog_line_fetcher.sv
// frog_line_fetcher: fetches one 32-pixel sprite row per blanking interval into a line buffer
// and replays it against the active-video column with one cycle of latency.
module frog_line_fetcher #(
   parameter int MIRROR  = 1,
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               line_start,
   input  logic [COORD_W-1:0] next_row,
   input  logic [COORD_W-1:0] frog_x,
   input  logic [COORD_W-1:0] frog_y,
   input  logic               active,
   input  logic [COORD_W-1:0] h_count,
   output logic [4:0]         rom_x,
   output logic [4:0]         rom_y,
   input  logic               rom_pixel,
   output logic               pixel_out,
   output logic               busy,
   output logic               overrun
);
   typedef enum logic [1:0] {IDLE, CHECK, FETCH} state_t;
   state_t state;
   logic [COORD_W-1:0] row_l, fx_l, fy_l, dy, dx;
   logic [4:0] col, x_hold, x_now;
   logic [31:0] buffer;
   logic line_hit;
   assign dy = row_l - fy_l;
   assign dx = h_count - fx_l;
   assign x_now = MIRROR != 0 ? 5'd31 - col : col;
   // during FETCH the ROM address tracks col directly so rom_pixel belongs to this cycle's bit
   assign rom_x = state == FETCH ? x_now : x_hold;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row_l     <= '0;
         fx_l      <= '0;
         fy_l      <= '0;
         col       <= '0;
         x_hold    <= '0;
         rom_y     <= '0;
         buffer    <= '0;
         line_hit  <= 1'b0;
         pixel_out <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pixel_out <= active && line_hit && dx[COORD_W-1:5] == '0 && state == IDLE && buffer[dx[4:0]];
         if (line_start) begin
            row_l <= next_row;
            fx_l  <= frog_x;
            fy_l  <= frog_y;
            state <= CHECK;
            busy  <= 1'b1;
            if (state != IDLE) begin
               overrun  <= 1'b1;
               line_hit <= 1'b0;
            end
         end else begin
            case (state)
               CHECK: begin
                  line_hit <= 1'b0;
                  if (dy[COORD_W-1:5] == '0) begin
                     rom_y <= dy[4:0];
                     col   <= '0;
                     state <= FETCH;
                  end else begin
                     buffer <= '0;
                     state  <= IDLE;
                     busy   <= 1'b0;
                  end
               end
               FETCH: begin
                  buffer[col] <= rom_pixel;
                  x_hold      <= x_now;
                  col         <= col + 5'd1;
                  if (col == 5'd31) begin
                     line_hit <= 1'b1;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/frog_line_fetcher.md
FROG_LINE_FETCHER -- requirements
Module: frog_line_fetcher

Interface
REQ-001 Parameter MIRROR, default 1: 1 = rom_x driven as 31-col; 0 = rom_x driven as col.
REQ-002 Parameter COORD_W, default 10: width of all screen coordinates.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 line_start  in  1  one-cycle pulse at start of horizontal blanking; requests fetch of the next line.
REQ-006 next_row  in  COORD_W  screen row to be displayed after this blanking; sampled with line_start.
REQ-007 frog_x  in  COORD_W  sprite left column; sampled with line_start.
REQ-008 frog_y  in  COORD_W  sprite top row; sampled with line_start.
REQ-009 active  in  1  display-enable for the current pixel.
REQ-010 h_count  in  COORD_W  current active-video column.
REQ-011 rom_x  out  5  column address to the 32x32 sprite ROM.
REQ-012 rom_y  out  5  row address to the sprite ROM.
REQ-013 rom_pixel  in  1  combinational ROM data for (rom_x, rom_y), valid in the same cycle.
REQ-014 pixel_out  out  1  registered sprite pixel for (h_count, current line).
REQ-015 busy  out  1  high in CHECK and FETCH.
REQ-016 overrun  out  1  sticky flag: line_start arrived while busy.

Function
REQ-017 FSM states: IDLE, CHECK, FETCH; reset state IDLE.
REQ-018 IDLE + line_start: latch next_row, frog_x, frog_y; -> CHECK.
REQ-019 CHECK, one cycle: dy = next_row - frog_y (COORD_W-bit unsigned, wraps); dy < 32 -> rom_y <= dy[4:0], col <= 0, -> FETCH; else clear line buffer, line_hit <= 0, -> IDLE.
REQ-020 FETCH: per cycle drive rom_x from col per MIRROR; write rom_pixel into buffer bit col; col increments.
REQ-021 FETCH with col == 31: write last bit, line_hit <= 1, -> IDLE; fetch totals exactly 32 FETCH cycles, 34 cycles from line_start to busy low.
REQ-022 rom_x, rom_y hold their last values outside FETCH.
REQ-023 dx = h_count - frog_x_latched (COORD_W-bit unsigned, wraps).
REQ-024 pixel_out next cycle = buffer[dx[4:0]] when active and line_hit and dx < 32 and not busy; else 0; latency 1 cycle.
REQ-025 frog_x > h_count: wrap yields dx >= 32, pixel_out = 0; right-edge clipping follows from active only.
REQ-026 line_start while busy: abort current fetch, re-latch inputs, restart at CHECK, set overrun; overrun clears only on rst.
REQ-027 line_start same cycle as FETCH col == 31: abort wins; partial line discarded, line_hit <= 0.
REQ-028 Buffer and line_hit persist in IDLE until next CHECK; no other path modifies them.

Reset
REQ-029 rst, in any state including mid-FETCH: state IDLE, col 0, buffer all 0, line_hit 0, latched coords 0, rom_x 0, rom_y 0, pixel_out 0, busy 0, overrun 0, on next edge.
REQ-030 rst has priority over line_start in the same cycle.

Verification
REQ-031 frog_y=100, next_row=103, frog_x=200, line_start -> busy high 33 cycles, rom_y=3, rom_x sweeps 31..0 (MIRROR=1); then h_count 200..231 with active -> pixel_out reproduces ROM row 3 one cycle late; h_count 199 and 232 -> 0.
REQ-032 next_row=99, frog_y=100 (dy wraps to 1023) -> no FETCH, busy high 1 cycle, pixel_out 0 across whole line.
REQ-033 frog_x=620, row hit -> pixel_out follows buffer for h_count 620..639; frog_x=5, h_count=2 -> 0 (wrap).
REQ-034 second line_start 10 cycles into FETCH -> overrun=1, fetch restarts with new next_row, completes 34 cycles after second pulse; overrun stays 1 until rst.
REQ-035 rst asserted at FETCH col=15 -> next cycle busy 0, pixel_out 0, buffer cleared (later hit with active shows 0 until new fetch).
REQ-036 MIRROR=0 build, same stimulus as REQ-031 -> rom_x sweeps 0..31, pixel_out order reversed relative to MIRROR=1.
